// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, taken-branch
// flush and data-memory wait freeze with timeout, plus a saturating stall counter.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memread,
  input  logic             mem_memread,
  input  logic             mem_memwrite,
  input  logic             mem_branch_taken,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             dmem_req,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             timeout_err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam int WC_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t          state, state_d;
  logic [WC_W-1:0] wait_cnt, wait_cnt_d;
  logic            mem_op, load_use;

  assign mem_op    = mem_memread | mem_memwrite;
  assign load_use  = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign dbg_state = state;

  // dmem handshake: dmem_req acts as valid and dmem_ready as ready; the access
  // completes in the cycle both are high, and req stays high (with the pipeline
  // frozen so address/data hold) until then.
  always_comb begin
    state_d      = state;
    wait_cnt_d   = wait_cnt;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;
    dmem_req     = mem_op;

    unique case (state)
      ST_RUN, ST_MEM_WAIT: begin
        if (state == ST_MEM_WAIT) dmem_req = 1'b1;
        if (mem_op && !dmem_ready) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
          memwb_bubble = 1'b1;
          dmem_req     = 1'b1;
          if (state == ST_RUN) begin
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = '0;
          end else if (wait_cnt == WC_LAST) begin
            state_d = ST_ERROR;
          end else begin
            wait_cnt_d = wait_cnt + 1'b1;
          end
        end else begin
          state_d = ST_RUN;
          if (mem_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
      end
      default: begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
        memwb_bubble = 1'b1;
        dmem_req     = 1'b0;
      end
    endcase

    // Reset freezes every register and aborts any outstanding memory access.
    if (rst) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      {ifid_flush, idex_flush, exmem_flush, memwb_bubble} = 4'b1111;
      dmem_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
      if (!pc_en && (state != ST_ERROR) && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + 1'b1;
      if (state_d == ST_ERROR)
        timeout_err <= 1'b1;
    end
  end

endmodule
